// File: rtl/sum_squares_fp16.sv
// Squared magnitude X^2 + Y^2 of a binary16 pair using one shared squarer.
// Sequence LOAD -> SQX -> SQY -> ADD -> DONE; releasing reset starts a new operation.
module sum_squares_fp16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Xin,
  input  logic [15:0] Yin,
  output logic [15:0] result,
  output logic        done,
  output logic [1:0]  OFUF
);

  localparam int unsigned EXP_W  = 5;
  localparam int unsigned FRAC_W = 10;
  localparam int unsigned SIG_W  = FRAC_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned SQE_W  = 7;
  localparam int unsigned AE_W   = SQE_W + 1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_SQX,
    S_SQY,
    S_ADD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [14:0]             r_x;
  logic [14:0]             r_y;
  logic [SIG_W-1:0]        r_sqx_sig;
  logic [SIG_W-1:0]        r_sqy_sig;
  logic signed [SQE_W-1:0] r_sqx_exp;
  logic signed [SQE_W-1:0] r_sqy_exp;
  logic [15:0]             r_result;
  logic                    r_done;
  logic [1:0]              r_ofuf;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_LOAD;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD:  w_state_next = S_SQX;
      S_SQX:   w_state_next = S_SQY;
      S_SQY:   w_state_next = S_ADD;
      S_ADD:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_DONE;
      default: w_state_next = S_LOAD;
    endcase
  end

  // Shared squarer: operand chosen by state
  logic [14:0]             w_op;
  logic [EXP_W-1:0]        w_op_exp;
  logic                    w_op_zero;
  logic [SIG_W-1:0]        w_op_sig;
  logic [PROD_W-1:0]       w_prod;
  logic                    w_sq_carry;
  logic [SQE_W-1:0]        w_sq_base;
  logic [SIG_W-1:0]        w_sq_sig;
  logic [SQE_W-1:0]        w_sq_exp;

  assign w_op       = (r_state == S_SQX) ? r_x : r_y;
  assign w_op_exp   = w_op[14:10];
  assign w_op_zero  = (w_op_exp == '0);
  assign w_op_sig   = {1'b1, w_op[FRAC_W-1:0]};
  assign w_prod     = PROD_W'(w_op_sig) * PROD_W'(w_op_sig);
  assign w_sq_carry = w_prod[PROD_W-1];
  assign w_sq_base  = SQE_W'({2'b00, w_op_exp} - 7'd15);

  // A zero square gets sig 0 and the most negative exponent so it never wins alignment
  assign w_sq_sig = w_op_zero ? '0 :
                    (w_sq_carry ? w_prod[21:11] : w_prod[20:10]);
  assign w_sq_exp = w_op_zero ? 7'h40 :
                    SQE_W'({w_sq_base[5:0], 1'b0} + {6'd0, w_sq_carry});

  // Adder: align smaller operand, add, single-step normalize
  logic signed [AE_W-1:0] w_ex;
  logic signed [AE_W-1:0] w_ey;
  logic                   w_x_big;
  logic signed [AE_W-1:0] w_big_exp;
  logic signed [AE_W-1:0] w_small_exp;
  logic [SIG_W-1:0]       w_big_sig;
  logic [SIG_W-1:0]       w_small_sig;
  logic [AE_W-1:0]        w_diff;
  logic [SIG_W-1:0]       w_small_sh;
  logic [SIG_W:0]         w_sum;
  logic [SIG_W-1:0]       w_norm_sig;
  logic signed [AE_W-1:0] w_norm_exp;
  logic signed [AE_W-1:0] w_bexp;
  logic                   w_both_zero;

  assign w_ex        = {r_sqx_exp[SQE_W-1], r_sqx_exp};
  assign w_ey        = {r_sqy_exp[SQE_W-1], r_sqy_exp};
  assign w_x_big     = (w_ex >= w_ey);
  assign w_big_exp   = w_x_big ? w_ex : w_ey;
  assign w_small_exp = w_x_big ? w_ey : w_ex;
  assign w_big_sig   = w_x_big ? r_sqx_sig : r_sqy_sig;
  assign w_small_sig = w_x_big ? r_sqy_sig : r_sqx_sig;
  assign w_diff      = $unsigned(w_big_exp - w_small_exp);
  assign w_small_sh  = (w_diff >= 8'd12) ? '0 : (w_small_sig >> w_diff[3:0]);
  assign w_sum       = {1'b0, w_big_sig} + {1'b0, w_small_sh};
  assign w_norm_sig  = w_sum[SIG_W] ? w_sum[SIG_W:1] : w_sum[SIG_W-1:0];
  assign w_norm_exp  = w_sum[SIG_W] ? (w_big_exp + 8'sd1) : w_big_exp;
  assign w_bexp      = w_norm_exp + 8'sd15;
  assign w_both_zero = (r_sqx_sig == '0) && (r_sqy_sig == '0);

  logic w_x_nan, w_y_nan, w_x_inf, w_y_inf;
  assign w_x_nan = (&r_x[14:10]) && (|r_x[9:0]);
  assign w_y_nan = (&r_y[14:10]) && (|r_y[9:0]);
  assign w_x_inf = (&r_x[14:10]) && !(|r_x[9:0]);
  assign w_y_inf = (&r_y[14:10]) && !(|r_y[9:0]);

  logic [15:0] w_res;
  logic [1:0]  w_of;

  // Final packing with specials taking priority over range checks
  always_comb begin
    w_res = 16'h0000;
    w_of  = 2'b00;
    if (w_x_nan || w_y_nan) begin
      w_res = 16'h7E00;
    end else if (w_x_inf || w_y_inf) begin
      w_res = 16'h7C00;
      w_of  = 2'b10;
    end else if (w_both_zero) begin
      w_res = 16'h0000;
    end else if (w_bexp >= 8'sd31) begin
      w_res = 16'h7C00;
      w_of  = 2'b10;
    end else if (w_bexp <= 8'sd0) begin
      w_of  = 2'b01;
    end else begin
      w_res = {1'b0, w_bexp[4:0], w_norm_sig[9:0]};
    end
  end

  logic w_unused;
  assign w_unused = ^{w_prod[9:0], w_norm_sig[10], w_bexp[7:5], Xin[15], Yin[15]};

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x       <= '0;
      r_y       <= '0;
      r_sqx_sig <= '0;
      r_sqy_sig <= '0;
      r_sqx_exp <= '0;
      r_sqy_exp <= '0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_ofuf    <= 2'b00;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_x <= Xin[14:0];
          r_y <= Yin[14:0];
        end
        S_SQX: begin
          r_sqx_sig <= w_sq_sig;
          r_sqx_exp <= w_sq_exp;
        end
        S_SQY: begin
          r_sqy_sig <= w_sq_sig;
          r_sqy_exp <= w_sq_exp;
        end
        S_ADD: begin
          r_result <= w_res;
          r_ofuf   <= w_of;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign OFUF   = r_ofuf;

endmodule
